// File: rtl/im2col_window_seq.sv
// Raster-scan request sequencer for im2Col: one request per valid kernel window, paced by valid/ready.
// Optional feature macro WIN_STRIDE_EN enables a programmable window stride (default: stride 1).
module im2col_window_seq #(
  parameter int ADDR_W = 8,
  parameter int KER_W  = 4,
  parameter int STR_W  = 3
) (
  input  logic                  iClk,
  input  logic                  iRst,
  input  logic                  iStart,
  input  logic [ADDR_W-1:0]     iImgW,
  input  logic [ADDR_W-1:0]     iImgH,
  input  logic [KER_W-1:0]      iKerW,
  input  logic [STR_W-1:0]      iStride,
  input  logic                  iRdy,
  output logic [KER_W-1:0]      oKerWidth,
  output logic [ADDR_W-1:0]     oStartX,
  output logic [ADDR_W-1:0]     oStartY,
  output logic                  oDv,
  output logic                  oBusy,
  output logic                  oDone,
  output logic                  oErr,
  output logic [2*ADDR_W-1:0]   oWinCnt
);

  localparam int AW1 = ADDR_W + 1;
  localparam int CW  = 2 * ADDR_W;

  typedef enum logic [1:0] {IDLE, CHECK, ISSUE, DONE} state_t;

  state_t            state;
  logic [ADDR_W-1:0] img_w, img_h;
  logic [AW1-1:0]    k_ext, lim_x, lim_y, step, x_nxt, y_nxt;
  logic              start_ok, xfer, x_wrap, y_end, too_big;

  assign start_ok = (state == IDLE) && iStart;
  assign xfer     = (state == ISSUE) && oDv && iRdy;

`ifdef WIN_STRIDE_EN
  logic [STR_W-1:0] stride;

  always_ff @(posedge iClk) begin
    if (start_ok) stride <= iStride;
  end

  assign step = AW1'(stride) + AW1'(1);
`else
  logic unused_stride;

  assign unused_stride = ^iStride;
  assign step          = AW1'(1);
`endif

  // Config is held only while a scan runs, so it needs no reset.
  always_ff @(posedge iClk) begin
    if (start_ok) begin
      img_w <= iImgW;
      img_h <= iImgH;
      k_ext <= AW1'(iKerW) + AW1'(1);
    end
  end

  // All compares are one bit wider than the address so sums cannot wrap.
  assign too_big = (k_ext > {1'b0, img_w}) || (k_ext > {1'b0, img_h});
  assign lim_x   = {1'b0, img_w} - k_ext;
  assign lim_y   = {1'b0, img_h} - k_ext;
  assign x_nxt   = {1'b0, oStartX} + step;
  assign y_nxt   = {1'b0, oStartY} + step;
  assign x_wrap  = x_nxt > lim_x;
  assign y_end   = y_nxt > lim_y;

  always_ff @(posedge iClk or negedge iRst) begin
    if (!iRst) begin
      state     <= IDLE;
      oKerWidth <= '0;
      oStartX   <= '0;
      oStartY   <= '0;
      oDv       <= 1'b0;
      oBusy     <= 1'b0;
      oDone     <= 1'b0;
      oErr      <= 1'b0;
      oWinCnt   <= '0;
    end else begin
      case (state)
        IDLE: begin
          oDone <= 1'b0;
          if (iStart) begin
            state     <= CHECK;
            oBusy     <= 1'b1;
            oErr      <= 1'b0;
            oWinCnt   <= '0;
            oStartX   <= '0;
            oStartY   <= '0;
            oKerWidth <= iKerW;
          end
        end
        CHECK: begin
          if (too_big) begin
            oErr  <= 1'b1;
            oDone <= 1'b1;
            state <= DONE;
          end else begin
            oDv   <= 1'b1;
            state <= ISSUE;
          end
        end
        ISSUE: begin
          if (xfer) begin
            oWinCnt <= oWinCnt + CW'(1);
            if (!x_wrap) begin
              oStartX <= x_nxt[ADDR_W-1:0];
            end else if (!y_end) begin
              oStartX <= '0;
              oStartY <= y_nxt[ADDR_W-1:0];
            end else begin
              oDv   <= 1'b0;
              oDone <= 1'b1;
              state <= DONE;
            end
          end
        end
        DONE: begin
          oDone <= 1'b0;
          oBusy <= 1'b0;
          state <= IDLE;
        end
        default: begin
          oDv   <= 1'b0;
          oBusy <= 1'b0;
          oDone <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_im2col_window_seq.sv
// Directed bench for im2col_window_seq: window order, stalls, error path, mid-scan restart and async reset.
module tb_im2col_window_seq;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        iStart;
  logic [7:0]  iImgW, iImgH;
  logic [3:0]  iKerW;
  logic [2:0]  iStride;
  logic        iRdy;
  logic [3:0]  oKerWidth;
  logic [7:0]  oStartX, oStartY;
  logic        oDv, oBusy, oDone, oErr;
  logic [15:0] oWinCnt;

  int n_total = 0;
  int n_bad   = 0;

  always #5 clk = ~clk;

  im2col_window_seq #(.ADDR_W(8), .KER_W(4), .STR_W(3)) dut (
    .iClk      (clk),
    .iRst      (rst_n),
    .iStart    (iStart),
    .iImgW     (iImgW),
    .iImgH     (iImgH),
    .iKerW     (iKerW),
    .iStride   (iStride),
    .iRdy      (iRdy),
    .oKerWidth (oKerWidth),
    .oStartX   (oStartX),
    .oStartY   (oStartY),
    .oDv       (oDv),
    .oBusy     (oBusy),
    .oDone     (oDone),
    .oErr      (oErr),
    .oWinCnt   (oWinCnt)
  );

  task automatic check(input string tag, input longint obs, input longint exp);
    n_total++;
    if (obs != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // mode 0: iRdy always high; mode 1: 1 high / 2 low; mode 2: iRdy high and a second start mid-scan
  task automatic scan(input string nm, input int w, input int h, input int kc, input int sc,
                      input int mode, input int exp_n);
    int idx, cyc, last_xfer, step, nx, ex, ey, dv_seen;
    bit got_done, stalled;
    logic [7:0] px, py;
    idx = 0; cyc = 0; last_xfer = -100; dv_seen = 0;
    got_done = 0; stalled = 0; px = 0; py = 0;
`ifdef WIN_STRIDE_EN
    step = sc + 1;
`else
    step = 1;
`endif
    nx = (w - (kc + 1)) / step + 1;
    if (nx < 1) nx = 1;
    @(negedge clk);
    iImgW = 8'(w); iImgH = 8'(h); iKerW = 4'(kc); iStride = 3'(sc);
    iStart = 1'b1;
    iRdy = (mode != 1);
    @(negedge clk);
    iStart = 1'b0;
    check({nm, "_busy_check"}, oBusy, 1);
    check({nm, "_dv_check"}, oDv, 0);
    check({nm, "_err_clr"}, oErr, 0);
    check({nm, "_cnt_clr"}, oWinCnt, 0);
    while (!got_done && cyc < 400) begin
      @(negedge clk);
      cyc++;
      if (oDv) dv_seen++;
      if (oDv && dv_seen == 1) check({nm, "_first_dv_lat"}, cyc, 1);
      if (stalled) begin
        check({nm, "_stall_x"}, oStartX, px);
        check({nm, "_stall_y"}, oStartY, py);
        check({nm, "_stall_dv"}, oDv, 1);
      end
      if (oDone) begin
        got_done = 1;
        if (exp_n == 0) check({nm, "_done_cyc"}, cyc, 1);
        else            check({nm, "_done_gap"}, cyc - last_xfer, 1);
        check({nm, "_done_dv"}, oDv, 0);
        check({nm, "_done_busy"}, oBusy, 1);
        check({nm, "_wincnt"}, oWinCnt, exp_n);
        check({nm, "_err"}, oErr, (exp_n == 0) ? 1 : 0);
      end else begin
        if (mode == 1) iRdy = (cyc % 3 == 0);
        if (mode == 2) begin
          iStart = (cyc == 2);
          if (cyc == 2) begin
            iImgW = 8'd9; iImgH = 8'd9; iKerW = 4'd0;
          end
        end
        if (oDv && iRdy) begin
          ex = (idx % nx) * step;
          ey = (idx / nx) * step;
          check($sformatf("%s_x%0d", nm, idx), oStartX, ex);
          check($sformatf("%s_y%0d", nm, idx), oStartY, ey);
          check($sformatf("%s_kw%0d", nm, idx), oKerWidth, kc);
          check($sformatf("%s_cnt%0d", nm, idx), oWinCnt, idx);
          idx++;
          last_xfer = cyc;
        end
        stalled = oDv && !iRdy;
        px = oStartX;
        py = oStartY;
      end
    end
    iStart = 1'b0;
    if (!got_done) check({nm, "_timeout"}, 0, 1);
    check({nm, "_n_xfer"}, idx, exp_n);
    check({nm, "_no_dv"}, (dv_seen == 0) ? 1 : 0, (exp_n == 0) ? 1 : 0);
    @(negedge clk);
    check({nm, "_idle_busy"}, oBusy, 0);
    check({nm, "_idle_done"}, oDone, 0);
    iRdy = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; iStart = 1'b0; iImgW = '0; iImgH = '0;
    iKerW = '0; iStride = '0; iRdy = 1'b0;
    repeat (2) @(negedge clk);
    check("reset_outs", {oDv, oBusy, oDone, oErr, oStartX, oStartY, oKerWidth, oWinCnt}, 0);
    rst_n = 1'b1;

    scan("t1_4x4k3", 4, 4, 2, 0, 0, 4);
    scan("t2_stall", 4, 4, 2, 0, 1, 4);
    scan("t3_err", 2, 5, 2, 0, 0, 0);
    scan("t4_restart", 4, 4, 2, 0, 2, 4);

    // async reset in the middle of a stalled scan
    @(negedge clk);
    iImgW = 8'd6; iImgH = 8'd6; iKerW = 4'd1; iStart = 1'b1; iRdy = 1'b0;
    @(negedge clk);
    iStart = 1'b0;
    repeat (3) @(negedge clk);
    check("pre_rst_dv", oDv, 1);
    #2 rst_n = 1'b0;
    #1 check("rst_async", {oDv, oBusy, oDone, oErr, oStartX, oStartY, oKerWidth, oWinCnt}, 0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("rst_hold", {oDv, oBusy, oDone}, 0);
    end
    rst_n = 1'b1;

    scan("t6_k1", 1, 1, 0, 0, 0, 1);
`ifdef WIN_STRIDE_EN
    scan("t5_stride", 7, 7, 2, 1, 0, 9);
`else
    scan("t5_nostride", 7, 7, 2, 1, 0, 25);
`endif

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
